rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Shares one output channel between NUM_REQ requesters.
- Sequences the select of an N:1 data multiplexer with a round-robin arbiter.
- Holds the grant for the whole packet (lock until `last`), so the packet is never interleaved.
- Sits in front of any shared sink that needs a single valid/ready stream. Output data is registered.

Parameters:
- NUM_REQ, 4, number of requesters (≥2; need not be a power of two).
- DATA_W, 8, data width per beat.
- SEL_W, $clog2(NUM_REQ), grant-index width. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_W  packed beats; requester i occupies [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  per-requester end-of-packet flag
- req_ready  out  NUM_REQ  per-requester beat accept
- out_valid  out  1  output beat valid (registered)
- out_data  out  DATA_W  output beat (registered)
- out_last  out  1  output end-of-packet flag (registered)
- out_ready  in  1  sink accept
- grant_sel  out  SEL_W  current mux select (registered)
- busy  out  1  high while a packet grant is locked

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE, ptr=0.
  - out_valid=0, out_data=0, out_last=0, grant_sel=0, busy=0.
  - req_ready=0.
- FSM states:
  - IDLE: no grant held.
    - If any req_valid is high, grant the first valid index at or after ptr, searching upward with wrap modulo NUM_REQ.
    - Register the winner into grant_sel and move to LOCKED.
    - Arbitration costs exactly 1 cycle. No beat is accepted in IDLE.
  - LOCKED: busy=1.
    - req_ready[grant_sel] = (!out_valid || out_ready). All other req_ready bits are 0.
    - A beat is accepted when req_valid[g] && req_ready[g]. It loads out_data/out_last from requester g and sets out_valid=1.
    - If the accepted beat has req_last=1: ptr <= (g+1) mod NUM_REQ (explicit compare-and-wrap, not a power-of-two mask) and the FSM moves to IDLE.
- Output register:
  - out_valid clears when out_ready=1 and no new beat is accepted in that cycle.
  - Accept and drain in the same cycle are allowed, giving 1 beat/cycle within a packet.
  - Latency from accepted req beat to out_valid is 1 cycle.
- Output stability: while out_valid=1 && out_ready=0, out_data and out_last hold stable.
- Grant switching: grant_sel changes only on the IDLE→LOCKED transition. It holds its old value in IDLE. It never changes mid-packet.
- Valid drop while LOCKED: if the granted requester drops req_valid mid-packet, the lock is kept and nothing is accepted. There is no timeout.
- Packet gap: consecutive packets have a minimum gap of 1 idle cycle on the input side for re-arbitration.
  - The output may still be draining during that cycle.
- Fairness:
  - A requester that has just finished is lowest priority next round.
  - A lone requester is re-granted back-to-back.
- Reset mid-packet: all state clears immediately. Any partial packet is dropped, and the sink sees out_valid fall asynchronously.
- req_valid on non-granted requesters has no effect while LOCKED. The winner is decided only on entry to LOCKED.

Decomposition:
- Shared package mux_ctrl_pkg:
  - state enum {IDLE, LOCKED}.
  - A clog2-based width helper.
- One natural sub-module, rr_pick:
  - Combinational: inputs req vector and ptr; outputs winner index and any_req.
  - Implement as a rotate-then-priority-encode, or a double-width scan.
- The N:1 data select is an indexed part-select inside the top. No separate module.

Test Plan:
- Single requester: req_valid=0010, 3-beat packet 0xA1,0xA2,0xA3 (last on third), out_ready=1.
  - grant_sel=1 one cycle after valid.
  - out_data shows A1,A2,A3 on consecutive cycles.
  - busy falls after the A3 accept. ptr=2.
- Round robin: all four requesters valid continuously, 1-beat packets, data=0x10*i.
  - Output order is 0x00,0x10,0x20,0x30,0x00 with one bubble between packets.
- Backpressure: out_ready=0 for 3 cycles mid-packet.
  - out_data holds stable and req_ready[g]=0.
  - Resume releases the next beat with no loss or duplication.
- Non-power-of-two wrap: NUM_REQ=3, requester 2 finishes with requesters 0 and 2 valid.
  - Next grant is 0 (ptr wraps 3→0).
- Lock hold: requester 1 granted, drops valid for 4 cycles mid-packet while requester 3 is valid.
  - grant_sel stays 1 and req_ready[3]=0 throughout.
  - Requester 1 finishes its packet, then requester 3 is granted.
- Async reset mid-packet: assert rst_n=0 between clock edges while out_valid=1.
  - out_valid, busy and req_ready go to 0 immediately.
  - After release, ptr=0 and requester 0 wins a fresh contest.

Source files
------------

// File: rtl/mux_ctrl_pkg.sv
// Shared types and helpers for the round-robin packet mux arbiter.
package mux_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Grant-index width; a single requester still needs a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and sink-side stream bundle for rr_mux_arbiter.
interface rr_mux_arbiter_if import mux_ctrl_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = sel_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      out_ready;
  logic [SEL_W-1:0]          grant_sel;
  logic                      busy;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, grant_sel, busy
  );

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, grant_sel, busy
  );
endinterface

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick import mux_ctrl_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = sel_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any_req
);

  // Explicit compare-and-wrap so non-power-of-two NUM_REQ stays in range.
  function automatic logic [SEL_W-1:0] idx_at(input logic [SEL_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SEL_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    winner  = ptr;
    any_req = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[idx_at(ptr, i)]) winner = idx_at(ptr, i);
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 packet mux: grant locked until last, registered output stage.
module rr_mux_arbiter import mux_ctrl_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int SEL_W  = sel_width(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux_arbiter_if.slave   bus
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    grant_q, grant_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  logic [SEL_W-1:0]    pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  ready;
  logic                accept;

  rr_pick #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_pick (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    ready       = '0;
    accept      = 1'b0;

    // Only the locked winner sees ready; it flows whenever the output slot frees.
    if (state_q == LOCKED) begin
      ready[grant_q] = !out_valid_q || bus.out_ready;
      accept         = bus.req_valid[grant_q] && ready[grant_q];
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.req_data[grant_q*DATA_W +: DATA_W];
      out_last_d  = bus.req_last[grant_q];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && bus.req_last[grant_q]) begin
          ptr_d   = (grant_q == SEL_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.grant_sel = grant_q;
  assign bus.busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized and directed checks of rr_mux_arbiter (NUM_REQ=4 and NUM_REQ=3).
module tb_rr_mux_arbiter;
  import mux_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) b4();
  rr_mux_arbiter_if #(.NUM_REQ(3), .DATA_W(8)) b3();

  rr_mux_arbiter #(.NUM_REQ(4), .DATA_W(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  rr_mux_arbiter #(.NUM_REQ(3), .DATA_W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  int total = 0;
  int bad   = 0;

  // Per-requester beat queues {last, data} and the captured output stream.
  logic [8:0] pq [4][$];
  logic [8:0] got [$];

  // Values sampled at the falling edge by step().
  logic [3:0] s_rdy;
  logic       s_ov, s_ol, s_busy;
  logic [7:0] s_od;
  logic [1:0] s_gs;

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) pq[i].delete();
    got.delete();
    b4.req_valid = '0; b4.req_data = '0; b4.req_last = '0; b4.out_ready = 1'b1;
    b3.req_valid = '0; b3.req_data = '0; b3.req_last = '0; b3.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One cycle on b4: present queue heads, sample at negedge, pop accepted beats.
  task automatic step(input logic [3:0] vmask, input logic ordy);
    logic [3:0] fire;
    for (int i = 0; i < 4; i++) begin
      b4.req_valid[i]        = vmask[i] && (pq[i].size() > 0);
      b4.req_data[i*8 +: 8]  = (pq[i].size() > 0) ? pq[i][0][7:0] : 8'h00;
      b4.req_last[i]         = (pq[i].size() > 0) ? pq[i][0][8] : 1'b0;
    end
    b4.out_ready = ordy;
    @(negedge clk);
    s_rdy = b4.req_ready; s_ov = b4.out_valid; s_od = b4.out_data;
    s_ol = b4.out_last; s_gs = b4.grant_sel; s_busy = b4.busy;
    fire = b4.req_valid & b4.req_ready;
    if (b4.out_valid && b4.out_ready) got.push_back({b4.out_last, b4.out_data});
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) if (fire[i]) void'(pq[i].pop_front());
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst_n = 1'b0;
    #2;
    total++; if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", b4.out_valid); end
    total++; if (b4.out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%0h exp=0", b4.out_data); end
    total++; if (b4.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%0b exp=0", b4.out_last); end
    total++; if (b4.grant_sel !== 2'd0) begin bad++; $display("FAIL rst_grant_sel got=%0d exp=0", b4.grant_sel); end
    total++; if (b4.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", b4.busy); end
    total++; if (b4.req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0000", b4.req_ready); end
    total++; if (b3.out_valid !== 1'b0 || b3.busy !== 1'b0) begin bad++; $display("FAIL rst_n3 got=%0b%0b exp=00", b3.out_valid, b3.busy); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3;
    pq[1].push_back({1'b0, 8'hA1}); pq[1].push_back({1'b0, 8'hA2}); pq[1].push_back({1'b1, 8'hA3});
    step(4'b0010, 1'b1);
    total++; if (s_busy !== 1'b0 || s_rdy !== 4'b0) begin bad++; $display("FAIL single_idle busy=%0b rdy=%b exp busy=0 rdy=0000", s_busy, s_rdy); end
    step(4'b0010, 1'b1);
    total++; if (s_gs !== 2'd1 || s_rdy !== 4'b0010) begin bad++; $display("FAIL single_grant gs=%0d rdy=%b exp gs=1 rdy=0010", s_gs, s_rdy); end
    repeat (3) step(4'b0010, 1'b1);
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%0b exp=0", s_busy); end
    total++; if (got.size() !== 3) begin bad++; $display("FAIL single_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= got.size() || got[i] !== {(i == 2), exp_d[i]}) begin
        bad++; $display("FAIL single_beat%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 9'h1ff, {(i == 2), exp_d[i]});
      end
    end
    // ptr should now be 2: with 0,1,3 requesting, 3 is first at or above 2.
    pq[0].push_back({1'b1, 8'h01}); pq[1].push_back({1'b1, 8'h11}); pq[3].push_back({1'b1, 8'h31});
    step(4'b1011, 1'b1);
    step(4'b1011, 1'b1);
    total++; if (s_gs !== 2'd3) begin bad++; $display("FAIL single_ptr2 gs=%0d exp=3", s_gs); end
  endtask

  task automatic test_round_robin();
    int cyc [$];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pq[i].push_back({1'b1, 8'(16 * i)}); pq[i].push_back({1'b1, 8'(16 * i)});
    end
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      int n;
      n = got.size();
      step(4'b1111, 1'b1);
      if (got.size() > n) cyc.push_back(c);
    end
    total++; if (got.size() < 5) begin bad++; $display("FAIL rr_timeout got=%0d beats exp=5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      total++;
      if (got[i][7:0] !== 8'(16 * (i % 4))) begin bad++; $display("FAIL rr_order%0d got=%h exp=%h", i, got[i][7:0], 8'(16 * (i % 4))); end
    end
    for (int i = 1; i < cyc.size(); i++) begin
      total++;
      if (cyc[i] - cyc[i-1] != 2) begin bad++; $display("FAIL rr_gap%0d got=%0d exp=2", i, cyc[i] - cyc[i-1]); end
    end
  endtask

  task automatic test_backpressure();
    logic pv, pr; logic [7:0] pd;
    do_reset();
    for (int i = 0; i < 5; i++) pq[0].push_back({(i == 4), 8'(8'h50 + i)});
    pv = 1'b0; pr = 1'b1; pd = '0;
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      logic r;
      r = !(c >= 4 && c <= 6);
      step(4'b0001, r);
      if (pv && !pr) begin
        total++;
        if (s_ov !== 1'b1 || s_od !== pd) begin bad++; $display("FAIL bp_hold got=%0b/%h exp=1/%h", s_ov, s_od, pd); end
      end
      if (s_ov && !r) begin
        total++;
        if (s_rdy[0] !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b exp=0", s_rdy[0]); end
      end
      pv = s_ov; pr = r; pd = s_od;
    end
    total++; if (got.size() !== 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      total++;
      if (got[i] !== {(i == 4), 8'(8'h50 + i)}) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got[i], {(i == 4), 8'(8'h50 + i)}); end
    end
  endtask

  task automatic test_wrap3();
    do_reset();
    b3.req_valid = 3'b100; b3.req_data[2*8 +: 8] = 8'h22; b3.req_last = 3'b101; b3.out_ready = 1'b1;
    @(posedge clk); #1;
    b3.req_valid = 3'b101; b3.req_data[0 +: 8] = 8'h02;
    @(negedge clk);
    total++; if (b3.grant_sel !== 2'd2 || b3.req_ready !== 3'b100) begin bad++; $display("FAIL wrap_grant2 gs=%0d rdy=%b exp gs=2 rdy=100", b3.grant_sel, b3.req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (b3.out_data !== 8'h22 || b3.busy !== 1'b0) begin bad++; $display("FAIL wrap_out d=%h busy=%0b exp d=22 busy=0", b3.out_data, b3.busy); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (b3.grant_sel !== 2'd0) begin bad++; $display("FAIL wrap_next gs=%0d exp=0", b3.grant_sel); end
    @(posedge clk); #1;
    b3.req_valid = '0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_lock_hold();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h12; exp_d[2] = 8'h13; exp_d[3] = 8'h31;
    do_reset();
    pq[1].push_back({1'b0, 8'h11}); pq[1].push_back({1'b0, 8'h12}); pq[1].push_back({1'b1, 8'h13});
    pq[3].push_back({1'b1, 8'h31});
    step(4'b0010, 1'b1);
    step(4'b1010, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step(4'b1000, 1'b1);
      total++;
      if (s_gs !== 2'd1 || s_rdy[3] !== 1'b0 || s_busy !== 1'b1) begin
        bad++; $display("FAIL lock_hold%0d gs=%0d rdy3=%0b busy=%0b exp 1/0/1", c, s_gs, s_rdy[3], s_busy);
      end
    end
    for (int c = 0; c < 20 && got.size() < 4; c++) step(4'b1010, 1'b1);
    total++; if (got.size() !== 4) begin bad++; $display("FAIL lock_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++;
      if (got[i][7:0] !== exp_d[i]) begin bad++; $display("FAIL lock_beat%0d got=%h exp=%h", i, got[i][7:0], exp_d[i]); end
    end
    total++; if (s_gs !== 2'd3) begin bad++; $display("FAIL lock_next gs=%0d exp=3", s_gs); end
  endtask

  task automatic test_async_reset();
    logic seen;
    do_reset();
    pq[1].push_back({1'b1, 8'h1F});
    for (int i = 0; i < 4; i++) pq[2].push_back({(i == 3), 8'(8'h20 + i)});
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(4'b0110, 1'b1);
      seen = s_ov && (s_od[7:4] == 4'h2);
    end
    total++; if (b4.out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre out_valid=%0b exp=1", b4.out_valid); end
    rst_n = 1'b0;
    #1;
    total++;
    if (b4.out_valid !== 1'b0 || b4.busy !== 1'b0 || b4.req_ready !== 4'b0) begin
      bad++; $display("FAIL arst_now ov=%0b busy=%0b rdy=%b exp 0/0/0000", b4.out_valid, b4.busy, b4.req_ready);
    end
    #2 rst_n = 1'b1;
    clear_inputs();
    pq[0].push_back({1'b1, 8'h01}); pq[2].push_back({1'b1, 8'h21}); pq[3].push_back({1'b1, 8'h31});
    step(4'b1101, 1'b1);
    step(4'b1101, 1'b1);
    total++; if (s_gs !== 2'd0 || s_busy !== 1'b1) begin bad++; $display("FAIL arst_fresh gs=%0d busy=%0b exp 0/1", s_gs, s_busy); end
  endtask

  task automatic test_random();
    logic [8:0] exp_s [$];
    int npk [4];
    int ptr;
    logic pv, pr, pl; logic [7:0] pd;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      npk[i] = $urandom_range(0, 3);
      for (int p = 0; p < npk[i]; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) pq[i].push_back({(b == len - 1), 2'(i), 2'(p), 2'(b), 2'b00});
      end
    end
    // Reference order: every requester keeps its queue valid, so grants walk round-robin over those with packets left.
    ptr = 0;
    while (npk[0] + npk[1] + npk[2] + npk[3] > 0) begin
      int k;
      k = ptr;
      while (npk[k] == 0) k = (k + 1) % 4;
      for (int j = 0; j < pq[k].size(); j++) begin
        if (pq[k][j][5:4] == 2'(4 - npk[k] - ((4 - npk[k]) - (pq[k][0][5:4] == 2'(0) ? 0 : 0)))) begin end
      end
      npk[k]--;
      ptr = (k + 1) % 4;
      exp_s.push_back({1'b0, 2'(k), 6'd0});
    end
    // Expand per-packet order into beats using copies of each requester's queue.
    begin
      logic [8:0] cp [4][$];
      logic [8:0] full [$];
      for (int i = 0; i < 4; i++) cp[i] = pq[i];
      for (int e = 0; e < exp_s.size(); e++) begin
        int k;
        logic [8:0] bt;
        k = int'(exp_s[e][7:6]);
        do begin
          bt = cp[k].pop_front();
          full.push_back(bt);
        end while (!bt[8]);
      end
      exp_s = full;
    end
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
    for (int c = 0; c < 3000 && got.size() < exp_s.size(); c++) begin
      logic r;
      r = ($urandom_range(0, 9) < 7);
      step(4'b1111, r);
      if (pv && !pr) begin
        total++;
        if (s_ov !== 1'b1 || s_od !== pd || s_ol !== pl) begin bad++; $display("FAIL rnd_hold got=%0b/%h/%0b exp=1/%h/%0b", s_ov, s_od, s_ol, pd, pl); end
      end
      pv = s_ov; pr = r; pd = s_od; pl = s_ol;
    end
    total++; if (got.size() !== exp_s.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", got.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_s[i]) begin bad++; $display("FAIL rnd_beat%0d got=%h exp=%h", i, got[i], exp_s[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap3();
    test_lock_hold();
    test_async_reset();
    for (int r = 0; r < 4; r++) test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
